// File: rtl/demux4_pkg.sv
// Shared constants and types for the 4-way demultiplexing buffer.
package demux4_pkg;
    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // FIFO occupancy: 0, 1 or 2 entries
    typedef logic [1:0] occ_t;
    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;
endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with a registered head; the head register keeps its last
// value when the FIFO drains so the output is stable while empty.
module demux_fifo2
    import demux4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output occ_t             count
);
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    occ_t             count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    count_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                // push+pop replaces the head in place; occupancy unchanged
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    count_d = OCC_FULL;
                end else if (pop) begin
                    count_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = OCC_ONE;
                end
            end
            default: count_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= OCC_EMPTY;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;
endmodule

// File: rtl/demux4_buf.sv
// Routes one input word per cycle to one of four buffered output channels
// and counts accepted words.
module demux4_buf
    import demux4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [CNT_W-1:0]        accept_cnt
);
    occ_t [NUM_CH-1:0]             cnt;
    logic [NUM_CH-1:0][WIDTH-1:0]  head;
    logic [NUM_CH-1:0]             push;
    logic [NUM_CH-1:0]             pop;
    logic                          accept;
    logic [CNT_W-1:0]              acc_cnt_q, acc_cnt_d;

    // Registered counts only: no combinational path from out_ready
    assign in_ready = rst_n && (cnt[in_sel] != OCC_FULL);
    assign accept   = in_valid && in_ready;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign push[ch]      = accept && (in_sel == SEL_W'(ch));
        assign out_valid[ch] = (cnt[ch] != OCC_EMPTY);
        assign pop[ch]       = out_valid[ch] && out_ready[ch];

        demux_fifo2 #(.WIDTH(WIDTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[ch]),
            .push_data (in_data),
            .pop       (pop[ch]),
            .head      (head[ch]),
            .count     (cnt[ch])
        );
    end

    assign out_data = head;

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (accept) acc_cnt_d = acc_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt_q <= '0;
        else        acc_cnt_q <= acc_cnt_d;
    end

    assign accept_cnt = acc_cnt_q;
endmodule

// File: tb/tb_demux4_buf.sv
// Directed bench for demux4_buf (CNT_W=4 so the counter wrap is reachable).
module tb_demux4_buf;
    localparam int W  = 8;
    localparam int CW = 4;

    logic            clk;
    logic            rst_n;
    logic [W-1:0]    in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [4*W-1:0]  out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [CW-1:0]   accept_cnt;

    int total = 0;
    int bad   = 0;

    demux4_buf #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .accept_cnt (accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ch_data(input int k);
        return out_data[k*W +: W];
    endfunction

    task automatic push1(input logic [1:0] sel, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [W-1:0] q [4][$];

    initial begin
        int acc, cyc;
        logic [1:0] s;
        logic [3:0] pat;
        logic       rdy_exp;
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
        #12;
        chk("rst_valid", out_valid, 4'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_cnt", accept_cnt, 4'h0);
        chk("rst_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", in_ready, 1'b1);

        // single word to channel 2
        push1(2'd2, 8'hA1);
        chk("a1_valid", out_valid, 4'b0100);
        chk("a1_data", ch_data(2), 8'hA1);
        chk("a1_cnt", accept_cnt, 4'd1);
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        chk("a1_drained", out_valid, 4'b0000);
        chk("a1_hold", ch_data(2), 8'hA1);

        // fill channel 0, then drain in order
        push1(2'd0, 8'h11);
        push1(2'd0, 8'h22);
        in_sel = 2'd0; #1;
        chk("ch0_full_rdy", in_ready, 1'b0);
        in_sel = 2'd1; #1;
        chk("ch1_rdy", in_ready, 1'b1);
        chk("ch0_cnt", accept_cnt, 4'd3);
        out_ready = 4'b0001; #1;
        chk("ch0_first", ch_data(0), 8'h11);
        tick();
        chk("ch0_second_v", out_valid[0], 1'b1);
        chk("ch0_second", ch_data(0), 8'h22);
        tick();
        chk("ch0_empty", out_valid[0], 1'b0);
        out_ready = 4'b0000;

        // simultaneous push and pop at count 1
        push1(2'd1, 8'h55);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h66; out_ready = 4'b0010;
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("pp_head", ch_data(1), 8'h66);
        chk("pp_valid", out_valid, 4'b0010);
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
        chk("pp_count1", out_valid[1], 1'b0);
        chk("pp_cnt", accept_cnt, 4'd5);

        // full channel blocks even when popped the same edge
        push1(2'd3, 8'h33);
        push1(2'd3, 8'h44);
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h99; out_ready = 4'b1000; #1;
        chk("full_blk_rdy", in_ready, 1'b0);
        tick();
        out_ready = 4'b0000;
        chk("full_cnt", accept_cnt, 4'd7);
        chk("full_rdy_next", in_ready, 1'b1);
        chk("full_head", ch_data(3), 8'h44);
        in_valid = 1'b0;
        // in_sel with in_valid low has no effect
        in_sel = 2'd0; tick(); in_sel = 2'd2; tick();
        chk("idle_sel_cnt", accept_cnt, 4'd7);
        chk("idle_sel_valid", out_valid, 4'b1000);

        // reset between edges with ch0 holding two words
        push1(2'd0, 8'hC1);
        push1(2'd0, 8'hC2);
        #2 rst_n = 1'b0; #1;
        chk("mid_rst_valid", out_valid, 4'h0);
        chk("mid_rst_rdy", in_ready, 1'b0);
        chk("mid_rst_cnt", accept_cnt, 4'd0);
        chk("mid_rst_data", out_data, 32'h0);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
        tick();
        chk("rst_no_xfer", out_valid, 4'h0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1; #1;

        // 17 words across channels with a scoreboard; counter wraps to 1
        acc = 0; cyc = 0;
        while (acc < 17 && cyc < 200) begin
            s   = 2'((acc * 3 + acc / 4) % 4);
            pat = 4'(cyc * 5 + 3);
            in_valid = 1'b1; in_sel = s; in_data = 8'h80 + 8'(acc); out_ready = pat;
            #1;
            rdy_exp = (q[s].size() != 2);
            chk("sb_rdy", in_ready, rdy_exp);
            for (int k = 0; k < 4; k++) begin
                chk("sb_valid", out_valid[k], q[k].size() != 0);
                if (q[k].size() != 0) begin
                    chk("sb_data", ch_data(k), q[k][0]);
                    if (pat[k]) void'(q[k].pop_front());
                end
            end
            if (rdy_exp) begin
                q[s].push_back(8'h80 + 8'(acc));
                acc++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("sb_accepted", acc, 17);
        chk("wrap_cnt", accept_cnt, 4'd1);
        out_ready = 4'hF;
        cyc = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && cyc < 20) begin
            #1;
            for (int k = 0; k < 4; k++) begin
                chk("dr_valid", out_valid[k], q[k].size() != 0);
                if (q[k].size() != 0) begin
                    chk("dr_data", ch_data(k), q[k][0]);
                    void'(q[k].pop_front());
                end
            end
            tick();
            cyc++;
        end
        chk("dr_done", out_valid, 4'h0);
        chk("final_cnt", accept_cnt, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
